fifo_wptr_full: RTL
===================

Name: fifo_wptr_full

Overview:
- Write-side pointer and full-flag generator for the async FIFO in the cdc library.
- Keeps a binary write pointer and converts it to Gray with bin2gray for crossing into the read domain.
- Brings the read-domain Gray pointer in through a 2-flop synchronizer and converts it back with gray2bin to compute full, almost-full and fill level.
- Sits between the write client and the FIFO RAM and read-pointer block; everything runs in the write clock domain.

Parameters:
- DLY, 1, simulation-only delay on every register assignment; no synthesis meaning.
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH; legal range 2 or more.
- AF_MARGIN, 2, almost_full_o asserts when level is at or above DEPTH-AF_MARGIN; legal range 1 to DEPTH-1.

Ports:
- clk, input, 1, write-domain clock; rising edge.
- rstn, input, 1, asynchronous active-low reset.
- winc_i, input, 1, write request from the client.
- rptr_gray_i, input, ADDR_WIDTH+1, read-domain Gray pointer; asynchronous to clk.
- waddr_o, output, ADDR_WIDTH, RAM write address, equal to the low bits of the binary pointer.
- wen_o, output, 1, RAM write enable, equal to winc_i AND NOT full_o (combinational).
- wptr_gray_o, output, ADDR_WIDTH+1, registered Gray write pointer sent to the read domain.
- full_o, output, 1, FIFO full; registered.
- almost_full_o, output, 1, level at or above DEPTH-AF_MARGIN; registered.
- wlevel_o, output, ADDR_WIDTH+1, pessimistic fill level (0 to DEPTH); registered.
- overflow_o, output, 1, one-cycle pulse when a write is attempted while full; registered.

Behaviour:
- Reset (rstn low, asynchronous, no clock needed):
  - The binary pointer, wptr_gray_o, both synchronizer stages (rq1, rq2), full_o, almost_full_o, wlevel_o and overflow_o all clear to 0.
  - waddr_o reads 0 and wen_o is 0 whenever full_o is 0 and winc_i is 0.
- Accept rule: a write is accepted when winc_i=1 and full_o=0.
  - wbin_next = wbin+1, taken modulo 2**(ADDR_WIDTH+1); otherwise wbin_next = wbin.
- Gray encoding: wgray_next = wbin_next XOR (wbin_next>>1), produced by bin2gray.
  - wptr_gray_o updates on the same edge as wbin.
  - Only one bit of wptr_gray_o changes per accepted write, including at wrap.
  - wptr_gray_o is driven only from a register, never combinationally.
- Synchronizer: rq1 samples rptr_gray_i and rq2 samples rq1 on each edge.
  - rq2 is the only read-pointer value used by any other logic.
- Full flag: full_next = (wgray_next equals rq2 with its two MSBs inverted and its remaining bits unchanged).
  - full_o asserts on the same edge that registers the write that fills the FIFO; there is no lag on assertion.
  - Deassertion latency: when rptr_gray_i changes and is stable before edge k, rq1 takes it at edge k, rq2 at edge k+1, and full_o drops at edge k+2.
- Level: wlevel_next = (wbin_next - gray2bin(rq2)) modulo 2**(ADDR_WIDTH+1).
  - The level is never below the true occupancy.
  - almost_full_next = (wlevel_next >= DEPTH-AF_MARGIN).
- Overflow: overflow_o is 1 for exactly one cycle after each edge on which winc_i=1 and full_o=1.
  - On that edge the pointer and RAM are left unchanged.
- Simultaneous write and read-pointer update in the same cycle: the write is evaluated against the current full_o; the read update takes effect through the synchronizer latency above.
- Wrap: binary value 2**(ADDR_WIDTH+1)-1 advances to 0, and the Gray pointer goes from the top code to 0 with a single bit change.
- Reset asserted mid-operation: every register clears immediately; the first write accepted after reset release uses waddr_o=0.

Decomposition:
- No shared package; all constants (DEPTH = 1<<ADDR_WIDTH) are localparams.
- Instantiate the existing bin2gray (for wgray_next) and gray2bin (for rq2), each passing DLY and WIDTH=ADDR_WIDTH+1.
- The 2-flop synchronizer is a natural sub-module: sync_2ff, with parameters DLY and WIDTH.

Test Plan (ADDR_WIDTH=4, AF_MARGIN=2, DEPTH=16):
- Reset: rstn=0 with no clock running -> all outputs 0. Release reset, then one write with rptr_gray_i=0 -> wptr_gray_o=5'b00001, waddr_o=1, wlevel_o=1.
- Fill: 16 consecutive writes with rptr_gray_i=0.
  - After the 14th write: almost_full_o=1.
  - After the 16th write: wptr_gray_o=5'b11000, wlevel_o=16, full_o=1 on that same edge.
- Write while full: winc_i=1 for 3 cycles -> wen_o=0, pointer stays at 5'b11000, overflow_o high for 3 consecutive cycles, then 0.
- Drain sync: while full, set rptr_gray_i=5'b00001 just before edge k -> full_o=0 and wlevel_o=15 after edge k+2, not earlier.
- Wrap: write and advance rptr_gray_i continuously through 32 writes -> wptr_gray_o steps 5'b10000 -> 5'b00000 with a single bit change and waddr_o wraps 15 -> 0; full_o never asserts while level stays below 16.
- Mid-operation reset: with level 10, pull rstn low between edges -> outputs clear immediately; after release, the first accepted write gives wptr_gray_o=5'b00001.

Source files
------------

// File: rtl/bin2gray.sv
// Binary to Gray code converter (purely combinational).
module bin2gray #(
  parameter int DLY   = 1,
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // DLY is a simulation-only delay setting; it has no effect on this logic.
  if (DLY < 0) begin : g_dly_unused
  end

  // Adjacent-bit XOR gives a code where consecutive values differ in one bit.
  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray2bin.sv
// Gray code to binary converter (purely combinational).
module gray2bin #(
  parameter int DLY   = 1,
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // DLY is a simulation-only delay setting; it has no effect on this logic.
  if (DLY < 0) begin : g_dly_unused
  end

  // Each binary bit is the XOR of all Gray bits at or above its position.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin[gi] = ^gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus arriving from another clock domain.
module sync_2ff #(
  parameter int DLY   = 1,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // DLY is a simulation-only delay setting; it has no effect on this logic.
  if (DLY < 0) begin : g_dly_unused
  end

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full / almost-full / level / overflow generation for the
// async FIFO. All logic runs in the write clock domain.
module fifo_wptr_full #(
  parameter int DLY        = 1,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  winc_i,
  input  logic [ADDR_WIDTH:0]   rptr_gray_i,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic                  wen_o,
  output logic [ADDR_WIDTH:0]   wptr_gray_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   wlevel_o,
  output logic                  overflow_o
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wbin_reg;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] wptr_gray_reg;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wlevel_reg;
  logic [PW-1:0] wlevel_next;
  logic          full_reg;
  logic          full_next;
  logic          af_reg;
  logic          af_next;
  logic          ovf_reg;
  logic          ovf_next;
  logic          accept;

  // Bring the read pointer into this domain; only the settled rq2 is used.
  sync_2ff #(.DLY(DLY), .WIDTH(PW)) u_rptr_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rptr_gray_i),
    .q    (rq2)
  );

  gray2bin #(.DLY(DLY), .WIDTH(PW)) u_rq2_bin (
    .gray (rq2),
    .bin  (rbin)
  );

  bin2gray #(.DLY(DLY), .WIDTH(PW)) u_wgray (
    .bin  (wbin_next),
    .gray (wgray_next)
  );

  assign accept = winc_i & ~full_reg;

  // Next-state pointer and flags, all evaluated on the post-write pointer so
  // that full asserts on the very edge that stores the last free slot.
  always_comb begin
    wbin_next   = wbin_reg + {{ADDR_WIDTH{1'b0}}, accept};
    full_next   = (wgray_next == {~rq2[PW-1:PW-2], rq2[PW-3:0]});
    wlevel_next = wbin_next - rbin;
    af_next     = (wlevel_next >= AF_LEVEL);
    ovf_next    = winc_i & full_reg;
  end

  // State registers; Gray pointer is registered so the crossing sees glitch-free bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbin_reg      <= '0;
      wptr_gray_reg <= '0;
      full_reg      <= 1'b0;
      af_reg        <= 1'b0;
      wlevel_reg    <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      wbin_reg      <= wbin_next;
      wptr_gray_reg <= wgray_next;
      full_reg      <= full_next;
      af_reg        <= af_next;
      wlevel_reg    <= wlevel_next;
      ovf_reg       <= ovf_next;
    end
  end

  assign waddr_o       = wbin_reg[ADDR_WIDTH-1:0];
  assign wen_o         = accept;
  assign wptr_gray_o   = wptr_gray_reg;
  assign full_o        = full_reg;
  assign almost_full_o = af_reg;
  assign wlevel_o      = wlevel_reg;
  assign overflow_o    = ovf_reg;

endmodule
